lp_cmd_scheduler: RTL and testbench

- Arbitrates linear-point commands from NUM_REQ requesters and drives the point-bank command interface (lp, object number, command, enable).
- Issues one command at a time.
- After each command, watches the addressed point's 5-bit status slice for a change, or times out.
- Reports completion per command to the winning requester.

---
 rtl/lp_sched_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 52 +++++
 rtl/lp_cmd_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_lp_cmd_scheduler.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lp_sched_pkg.sv
// Shared types and widths for the linear-point command scheduler.
// Holds FSM state, completion error codes and bank field widths.
package lp_sched_pkg;

    localparam int LP_W     = 3;
    localparam int OBJ_W    = 3;
    localparam int STATUS_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_BAD_LP  = 2'd2
    } err_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, registered pointer.
// Ports: i_clk, i_rst (sync high), i_req, i_en (grant allowed),
//        o_gnt (one-hot), o_idx (winner index), o_valid (a grant is out).
module rr_arbiter #(
    parameter  int N     = 2,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N-1:0]     i_req,
    input  logic             i_en,
    output logic [N-1:0]     o_gnt,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_valid
);

    logic [PTR_W-1:0] r_ptr;

    // Winner is the requester at the smallest forward distance
    // from the pointer, which is the "search upward and wrap" rule.
    always_comb begin
        int w_best;
        int w_dist;
        w_best  = N;
        w_dist  = 0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int j = 0; j < N; j++) begin
            w_dist = (j + N - int'(r_ptr)) % N;
            if (i_en && i_req[j] && w_dist < w_best) begin
                w_best  = w_dist;
                o_idx   = PTR_W'(j);
                o_valid = 1'b1;
            end
        end
    end

    assign o_gnt = o_valid ? (N'(1) << o_idx) : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (o_valid) begin
            if (o_idx == PTR_W'(N - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= o_idx + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/lp_cmd_scheduler.sv
// Arbitrates point-bank commands from NUM_REQ requesters, issues one at a
// time, then waits for the addressed status slice to change or time out.
// Ports: clk_i/rst_i; req_*_i requester bundles, gnt_o one-hot grant;
//        status_i bank status; lp_o/object_number_o/command_o/en_o bank
//        command; busy_o; done_o/done_id_o/err_o/result_o completion.
module lp_cmd_scheduler
    import lp_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int NUM_LP  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [3*NUM_REQ-1:0]     req_lp_i,
    input  logic [3*NUM_REQ-1:0]     req_obj_i,
    input  logic [NUM_REQ-1:0]       req_cmd_i,
    output logic [NUM_REQ-1:0]       gnt_o,
    input  logic [5*NUM_LP-1:0]      status_i,
    output logic [2:0]               lp_o,
    output logic [2:0]               object_number_o,
    output logic                     command_o,
    output logic                     en_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [2:0]               done_id_o,
    output logic [1:0]               err_o,
    output logic [4:0]               result_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    state_t              r_state;
    logic [LP_W-1:0]     r_lp;
    logic [OBJ_W-1:0]    r_obj;
    logic                r_cmd;
    logic [2:0]          r_id;
    logic [STATUS_W-1:0] r_snap;
    logic [CNT_W-1:0]    r_cnt;
    logic [LP_W-1:0]     r_lp_o;
    logic [OBJ_W-1:0]    r_obj_o;
    logic                r_cmd_o;
    logic                r_en;
    logic                r_done;
    logic [2:0]          r_done_id;
    err_t                r_err;
    logic [STATUS_W-1:0] r_result;

    logic                w_gnt_en;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [PTR_W-1:0]    w_win;
    logic                w_valid;
    logic [LP_W-1:0]     w_sel_lp;
    logic [OBJ_W-1:0]    w_sel_obj;
    logic                w_sel_cmd;
    logic                w_bad;
    logic [STATUS_W-1:0] w_cur;
    logic                w_tmo;

    // No grant while reset is asserted, so a held request is not
    // consumed by a cycle whose effects reset discards.
    assign w_gnt_en = (r_state == IDLE) && !rst_i;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_req   (req_i),
        .i_en    (w_gnt_en),
        .o_gnt   (w_gnt),
        .o_idx   (w_win),
        .o_valid (w_valid)
    );

    always_comb begin
        w_sel_lp  = '0;
        w_sel_obj = '0;
        w_sel_cmd = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_win == PTR_W'(j)) begin
                w_sel_lp  = req_lp_i[3*j +: 3];
                w_sel_obj = req_obj_i[3*j +: 3];
                w_sel_cmd = req_cmd_i[j];
            end
        end
    end

    always_comb begin
        w_cur = '0;
        for (int p = 0; p < NUM_LP; p++) begin
            if (r_lp == LP_W'(p)) begin
                w_cur = status_i[STATUS_W*p +: STATUS_W];
            end
        end
    end

    assign w_bad = int'(w_sel_lp) >= NUM_LP;
    assign w_tmo = r_cnt == CNT_W'(TIMEOUT - 1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_lp      <= '0;
            r_obj     <= '0;
            r_cmd     <= 1'b0;
            r_id      <= '0;
            r_snap    <= '0;
            r_cnt     <= '0;
            r_lp_o    <= '0;
            r_obj_o   <= '0;
            r_cmd_o   <= 1'b0;
            r_en      <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_err     <= ERR_OK;
            r_result  <= '0;
        end else begin
            r_en   <= 1'b0;
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_lp  <= w_sel_lp;
                        r_obj <= w_sel_obj;
                        r_cmd <= w_sel_cmd;
                        r_id  <= 3'(w_win);
                        if (w_bad) begin
                            r_state   <= DONE;
                            r_done    <= 1'b1;
                            r_done_id <= 3'(w_win);
                            r_err     <= ERR_BAD_LP;
                            r_result  <= '0;
                        end else begin
                            r_state <= ISSUE;
                            r_en    <= 1'b1;
                            r_lp_o  <= w_sel_lp;
                            r_obj_o <= w_sel_obj;
                            r_cmd_o <= w_sel_cmd;
                        end
                    end
                end
                ISSUE: begin
                    r_snap  <= w_cur;
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // A change wins over a timeout in the same cycle.
                    if (w_cur != r_snap) begin
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        r_done_id <= r_id;
                        r_err     <= ERR_OK;
                        r_result  <= w_cur;
                    end else if (w_tmo) begin
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        r_done_id <= r_id;
                        r_err     <= ERR_TIMEOUT;
                        r_result  <= w_cur;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt_o           = w_gnt;
    assign lp_o            = r_lp_o;
    assign object_number_o = r_obj_o;
    assign command_o       = r_cmd_o;
    assign en_o            = r_en;
    assign busy_o          = r_state != IDLE;
    assign done_o          = r_done;
    assign done_id_o       = r_done_id;
    assign err_o           = r_err;
    assign result_o        = r_result;

endmodule

// File: tb/tb_lp_cmd_scheduler.sv
// Self-checking bench for lp_cmd_scheduler: directed scenarios with
// literal expectations plus randomized traffic against a timeline model.
module tb_lp_cmd_scheduler;

    localparam int NR = 2;
    localparam int NL = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [NR-1:0]   req_i;
    logic [3*NR-1:0] req_lp_i;
    logic [3*NR-1:0] req_obj_i;
    logic [NR-1:0]   req_cmd_i;
    logic [NR-1:0]   gnt_o;
    logic [5*NL-1:0] status_i;
    logic [2:0]      lp_o;
    logic [2:0]      object_number_o;
    logic            command_o;
    logic            en_o;
    logic            busy_o;
    logic            done_o;
    logic [2:0]      done_id_o;
    logic [1:0]      err_o;
    logic [4:0]      result_o;

    lp_cmd_scheduler #(
        .NUM_REQ (NR),
        .NUM_LP  (NL),
        .TIMEOUT (TO)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .req_i           (req_i),
        .req_lp_i        (req_lp_i),
        .req_obj_i       (req_obj_i),
        .req_cmd_i       (req_cmd_i),
        .gnt_o           (gnt_o),
        .status_i        (status_i),
        .lp_o            (lp_o),
        .object_number_o (object_number_o),
        .command_o       (command_o),
        .en_o            (en_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .done_id_o       (done_id_o),
        .err_o           (err_o),
        .result_o        (result_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // bench-side requester and bank state
    logic [NR-1:0]   pend;
    int              lpq  [NR];
    int              objq [NR];
    int              cmdq [NR];
    logic [5*NL-1:0] st;
    bit              keep_req;

    // model: one command described by its grant time and done time
    bit m_act;
    bit m_bad;
    int m_ptr;
    int m_tg;
    int m_win;
    int m_lp, m_obj, m_cmd;
    int m_done_at;
    int m_snap;
    int m_err, m_res;
    int m_lp_o, m_obj_o, m_cmd_o;
    int m_id_o, m_err_o, m_res_o;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int slice(input int p);
        return int'(st[5*p +: 5]);
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic model_reset();
        m_act   = 0;
        m_ptr   = 0;
        m_lp_o  = 0;
        m_obj_o = 0;
        m_cmd_o = 0;
        m_id_o  = 0;
        m_err_o = 0;
        m_res_o = 0;
    endtask

    // Apply the bench inputs for this cycle, then check every output.
    task automatic step();
        int eg, granted, cur, k;
        bit ee, ed;
        for (int r = 0; r < NR; r++) begin
            req_lp_i[3*r +: 3]  = 3'(lpq[r]);
            req_obj_i[3*r +: 3] = 3'(objq[r]);
            req_cmd_i[r]        = 1'(cmdq[r]);
        end
        req_i    = pend;
        status_i = st;
        #1;
        if (rst_i) begin
            model_reset();
            return;
        end
        eg      = 0;
        granted = -1;
        if (m_act && cyc == m_tg + 1 && !m_bad) begin
            m_lp_o  = m_lp;
            m_obj_o = m_obj;
            m_cmd_o = m_cmd;
        end
        if (m_act && cyc == m_done_at) begin
            m_id_o  = m_win;
            m_err_o = m_err;
            m_res_o = m_res;
        end
        ee = m_act && cyc == m_tg + 1 && !m_bad;
        ed = m_act && cyc == m_done_at;
        chk("busy", busy_o, m_act);
        if (!m_act) begin
            for (int i = 0; i < NR; i++) begin
                k = (m_ptr + i) % NR;
                if (granted < 0 && pend[k]) granted = k;
            end
            if (granted >= 0) begin
                eg    = 1 << granted;
                m_ptr = (granted + 1) % NR;
                m_act = 1;
                m_tg  = cyc;
                m_win = granted;
                m_lp  = lpq[granted];
                m_obj = objq[granted];
                m_cmd = cmdq[granted];
                m_bad = m_lp >= NL;
                m_done_at = -1;
                if (m_bad) begin
                    m_done_at = cyc + 1;
                    m_err = 2;
                    m_res = 0;
                end
            end
        end else if (!m_bad && m_done_at < 0) begin
            cur = slice(m_lp);
            if (cyc == m_tg + 1) begin
                m_snap = cur;
            end else if (cur != m_snap) begin
                m_done_at = cyc + 1;
                m_err = 0;
                m_res = cur;
            end else if (cyc - (m_tg + 2) == TO - 1) begin
                m_done_at = cyc + 1;
                m_err = 1;
                m_res = cur;
            end
        end
        chk("gnt", gnt_o, eg);
        chk("en", en_o, ee);
        chk("done", done_o, ed);
        chk("lp_o", lp_o, m_lp_o);
        chk("obj_o", object_number_o, m_obj_o);
        chk("cmd_o", command_o, m_cmd_o);
        chk("done_id", done_id_o, m_id_o);
        chk("err", err_o, m_err_o);
        chk("result", result_o, m_res_o);
        if (ed) m_act = 0;
        if (granted >= 0 && !keep_req) pend[granted] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        pend = '0;
        while (m_act && n < 40) begin
            tick();
            step();
            n++;
        end
        if (m_act) chk("drain_bound", 1, 0);
    endtask

    initial begin
        int ng, nidle, p;
        logic [NR-1:0] gq [4];
        rst_i     = 1'b1;
        req_i     = '0;
        req_lp_i  = '0;
        req_obj_i = '0;
        req_cmd_i = '0;
        status_i  = '0;
        pend      = '0;
        st        = '0;
        keep_req  = 0;
        for (int r = 0; r < NR; r++) begin
            lpq[r]  = 0;
            objq[r] = 0;
            cmdq[r] = 0;
        end
        model_reset();

        tick(); step();
        tick(); step();
        rst_i = 1'b0;
        tick(); step();
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_en", en_o, 0);
        chk("rst_gnt", gnt_o, 0);

        // valid command completed by a status change
        st[14:10] = 5'h03;
        tick(); step();
        for (int k = 0; k < 7; k++) begin
            tick();
            if (k == 0) begin
                pend[0] = 1'b1;
                lpq[0] = 2; objq[0] = 5; cmdq[0] = 1;
            end
            if (k == 4) st[14:10] = 5'h11;
            step();
            if (k == 0) chk("t1_gnt", gnt_o, 1);
            if (k == 1) begin
                chk("t1_en", en_o, 1);
                chk("t1_lp", lp_o, 2);
                chk("t1_obj", object_number_o, 5);
                chk("t1_cmd", command_o, 1);
            end
            if (k == 4) chk("t1_nodone", done_o, 0);
            if (k == 5) begin
                chk("t1_done", done_o, 1);
                chk("t1_id", done_id_o, 0);
                chk("t1_err", err_o, 0);
                chk("t1_res", result_o, 5'h11);
            end
        end
        drain();

        // timeout on a static slice
        st[9:5] = 5'h0A;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k == 0) begin
                pend[0] = 1'b1;
                lpq[0] = 1; objq[0] = 3; cmdq[0] = 0;
            end
            step();
            if (k == 1) chk("to_en", en_o, 1);
            if (k == 17) chk("to_early", done_o, 0);
            if (k == 18) begin
                chk("to_done", done_o, 1);
                chk("to_err", err_o, 1);
                chk("to_res", result_o, 5'h0A);
            end
        end
        drain();

        // change on the last WAIT cycle beats the timeout
        st[19:15] = 5'h04;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k == 0) begin
                pend[0] = 1'b1;
                lpq[0] = 3; objq[0] = 1; cmdq[0] = 1;
            end
            if (k == 17) st[19:15] = 5'h15;
            step();
            if (k == 16) chk("lw_early", done_o, 0);
            if (k == 18) begin
                chk("lw_done", done_o, 1);
                chk("lw_err", err_o, 0);
                chk("lw_res", result_o, 5'h15);
            end
        end
        drain();

        // out-of-range point
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 0) begin
                pend[1] = 1'b1;
                lpq[1] = 5; objq[1] = 2; cmdq[1] = 0;
            end
            step();
            if (k == 0) chk("bad_gnt", gnt_o, 2);
            if (k == 1) begin
                chk("bad_en", en_o, 0);
                chk("bad_done", done_o, 1);
                chk("bad_err", err_o, 2);
                chk("bad_id", done_id_o, 1);
                chk("bad_res", result_o, 0);
                chk("bad_lp_hold", lp_o, 3);
            end
        end
        drain();

        // round-robin with both requesters held
        lpq[0] = 0; lpq[1] = 0;
        pend = 2'b11;
        keep_req = 1;
        ng = 0;
        nidle = 0;
        for (int i = 0; i < 4; i++) gq[i] = '0;
        for (int k = 0; k < 16; k++) begin
            tick();
            st[4:0] = st[4:0] ^ 5'h01;
            step();
            if (!busy_o) nidle++;
            if (gnt_o != '0) begin
                if (ng < 4) gq[ng] = gnt_o;
                ng++;
            end
        end
        keep_req = 0;
        chk("rr_count", ng, 4);
        chk("rr_idle", nidle, 4);
        chk("rr_g0", gq[0], 1);
        chk("rr_g1", gq[1], 2);
        chk("rr_g2", gq[2], 1);
        chk("rr_g3", gq[3], 2);
        drain();

        // reset in the middle of WAIT
        st[14:10] = 5'h07;
        for (int k = 0; k < 13; k++) begin
            tick();
            if (k == 0) begin
                pend[0] = 1'b1;
                lpq[0] = 2; objq[0] = 1; cmdq[0] = 1;
            end
            if (k == 4) rst_i = 1'b1;
            if (k == 5) begin
                rst_i = 1'b0;
                pend[1] = 1'b1;
                lpq[1] = 1; objq[1] = 3; cmdq[1] = 0;
            end
            if (k == 9) st[9:5] = st[9:5] ^ 5'h1F;
            step();
            if (k == 5) begin
                chk("rm_busy", busy_o, 0);
                chk("rm_done", done_o, 0);
                chk("rm_en", en_o, 0);
                chk("rm_lp", lp_o, 0);
                chk("rm_obj", object_number_o, 0);
                chk("rm_cmd", command_o, 0);
                chk("rm_err", err_o, 0);
                chk("rm_res", result_o, 0);
                chk("rm_id", done_id_o, 0);
                chk("rm_gnt", gnt_o, 2);
            end
            if (k == 6) begin
                chk("rm_en2", en_o, 1);
                chk("rm_lp2", lp_o, 1);
            end
            if (k == 10) begin
                chk("rm_done2", done_o, 1);
                chk("rm_id2", done_id_o, 1);
                chk("rm_err2", err_o, 0);
                chk("rm_res2", result_o, 5'h15);
            end
        end
        drain();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst_i = ($urandom_range(0, 499) == 0);
            for (int r = 0; r < NR; r++) begin
                if (!pend[r] && $urandom_range(0, 3) == 0) begin
                    pend[r] = 1'b1;
                    if ($urandom_range(0, 7) == 0)
                        lpq[r] = $urandom_range(4, 7);
                    else
                        lpq[r] = $urandom_range(0, 3);
                    objq[r] = $urandom_range(0, 7);
                    cmdq[r] = $urandom_range(0, 1);
                end
            end
            if ($urandom_range(0, 9) == 0) begin
                p = $urandom_range(0, NL - 1);
                st[5*p +: 5] = 5'($urandom_range(0, 31));
            end
            step();
        end
        rst_i = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
